// File: rtl/wallace_mul_arbiter_if.sv
// Requester and response channel bundle for the shared multiplier arbiter.
// Latency: none, wires only.
// Backpressure: req_ready per requester, and rsp_ready from the single consumer.
interface wallace_mul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [7:0]        rsp_prod;

  // Client side: drives operands and consumes tagged products.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_prod
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_prod
  );
endinterface

// File: rtl/wallace_mul_arbiter.sv
// Round-robin share of one external 4x4 multiplier among NREQ requesters.
// Latency: 2 cycles from request handshake to rsp_valid; one transaction every 3 cycles at best.
// Backpressure: a stalled response holds the FSM in RESP, so req_ready stays low until rsp_ready.
module wallace_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wallace_mul_arbiter_if.slave bus,
  output logic [3:0]           mul_a,
  output logic [3:0]           mul_b,
  input  logic [7:0]           mul_prod,
  output logic                 busy,
  output logic [15:0]          op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] tag_q;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] ptr_nxt;
  logic            gnt_vld;
  logic            accept;
  logic [3:0]      op_a_q, op_b_q;
  logic [3:0]      a_arr [NREQ];
  logic [3:0]      b_arr [NREQ];
  logic            rsp_valid_q;
  logic [7:0]      rsp_prod_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [15:0]     op_count_q;

  // Split the flat operand buses into per-requester lanes.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = bus.req_a[4*i +: 4];
      b_arr[i] = bus.req_b[4*i +: 4];
    end
  end

  // Round-robin search: first valid requester at or above ptr, wrapping at NREQ.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_vld && bus.req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
      cand = (cand == ID_W'(NREQ - 1)) ? '0 : cand + ID_W'(1);
    end
  end

  assign accept  = (state_q == IDLE) && gnt_vld;
  assign ptr_nxt = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);

  // One-hot ready to the granted requester; forced low while reset is held.
  always_comb begin
    bus.req_ready = '0;
    if (accept && rst_n) begin
      bus.req_ready[gnt_idx] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept -> one multiply cycle -> hold response until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MUL;
      MUL:     state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand/tag capture on grant, product capture after MUL, response retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      tag_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_prod_q  <= '0;
      rsp_id_q    <= '0;
      op_count_q  <= '0;
    end else begin
      if (accept) begin
        op_a_q <= a_arr[gnt_idx];
        op_b_q <= b_arr[gnt_idx];
        tag_q  <= gnt_idx;
        ptr_q  <= ptr_nxt;
      end
      if (state_q == MUL) begin
        rsp_prod_q  <= mul_prod;
        rsp_id_q    <= tag_q;
        rsp_valid_q <= 1'b1;
      end
      if (state_q == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
        op_count_q  <= op_count_q + 16'd1;
      end
    end
  end

  // Operand registers only change on a grant, so the multiplier inputs hold outside MUL.
  assign mul_a        = op_a_q;
  assign mul_b        = op_b_q;
  assign busy         = (state_q != IDLE);
  assign op_count     = op_count_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_prod  = rsp_prod_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Bench for wallace_mul_arbiter: transaction-level model plus scoreboard queue.
// Latency: expectations are stepped once per clock alongside the DUT.
// Backpressure: rsp_ready is driven low in directed and random phases.
module tb_wallace_mul_arbiter;
  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int M_IDLE = 0;
  localparam int M_MUL  = 1;
  localparam int M_RESP = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_prod;
  logic        busy;
  logic [15:0] op_count;

  wallace_mul_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus();

  wallace_mul_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_prod (mul_prod),
    .busy     (busy),
    .op_count (op_count)
  );

  // Stand-in for the external combinational multiplier.
  assign mul_prod = {4'b0, mul_a} * {4'b0, mul_b};

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] prod;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_state = M_IDLE;
  int          m_ptr = 0;
  logic [15:0] m_count = 16'd0;
  logic [3:0]  m_a = 4'd0;
  logic [3:0]  m_b = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_ptr   = 0;
    m_count = 16'd0;
    exp_q.delete();
  endtask

  // Everything must read zero while reset is held, even with all requesters valid.
  task automatic reset_checks();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_prod",  32'(bus.rsp_prod), 32'd0);
    chk("rst_rsp_id",    32'(bus.rsp_id), 32'd0);
    chk("rst_mul_a",     32'(mul_a), 32'd0);
    chk("rst_mul_b",     32'(mul_b), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_op_count",  32'(op_count), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = '1;
    #1;
    reset_checks();
    bus.req_valid = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of stimulus: drive inputs, check this cycle against the model, advance the model.
  task automatic cycle(input logic [NREQ-1:0] v, input logic [4*NREQ-1:0] a,
                       input logic [4*NREQ-1:0] b, input logic rr, output int acc);
    logic [NREQ-1:0] exp_rdy;
    int   g;
    int   idx;
    exp_t e;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = rr;
    #1;
    g = -1;
    exp_rdy = '0;
    if (m_state == M_IDLE) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_state == M_RESP));
    chk("busy", 32'(busy), 32'(m_state != M_IDLE));
    chk("op_count", 32'(op_count), 32'(m_count));
    if (m_state == M_MUL) begin
      chk("mul_a", 32'(mul_a), 32'(m_a));
      chk("mul_b", 32'(mul_b), 32'(m_b));
    end
    if (m_state == M_RESP && exp_q.size() > 0) begin
      chk("rsp_id_hold", 32'(bus.rsp_id), 32'(exp_q[0].id));
      chk("rsp_prod_hold", 32'(bus.rsp_prod), 32'(exp_q[0].prod));
    end
    acc = g;
    case (m_state)
      M_IDLE: if (g >= 0) begin
        m_a = a[4*g +: 4];
        m_b = b[4*g +: 4];
        e.id   = 8'(g);
        e.prod = 8'(int'(m_a) * int'(m_b));
        exp_q.push_back(e);
        m_ptr   = (g + 1) % NREQ;
        m_state = M_MUL;
      end
      M_MUL: m_state = M_RESP;
      M_RESP: if (rr) begin
        m_state = M_IDLE;
        m_count = m_count + 16'd1;
      end
      default: m_state = M_IDLE;
    endcase
  endtask

  // Monitor: on every response handshake pop the oldest expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        chk("rsp_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_rsp_id", 32'(bus.rsp_id), 32'(e.id));
          chk("sb_rsp_prod", 32'(bus.rsp_prod), 32'(e.prod));
        end
      end
    end
  end

  initial begin
    int              acc;
    logic [NREQ-1:0] v;
    logic [4*NREQ-1:0] a, b;
    logic [7:0]      ids   [5];
    logic [7:0]      prods [5];
    int              nseen;

    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    #12;
    reset_checks();
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Single request from requester 2: 15*15.
    a = '0; b = '0;
    a[11:8] = 4'd15; b[11:8] = 4'd15;
    cycle(4'b0100, a, b, 1'b1, acc);
    cycle(4'b0000, a, b, 1'b1, acc);
    cycle(4'b0000, a, b, 1'b1, acc);
    chk("single_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_prod", 32'(bus.rsp_prod), 32'd225);
    chk("single_id", 32'(bus.rsp_id), 32'd2);
    cycle(4'b0000, a, b, 1'b1, acc);
    chk("single_count", 32'(op_count), 32'd1);

    // Fairness: pointer now at 3, requesters 1 and 3 valid.
    a = {4'd9, 4'd2, 4'd5, 4'd1};
    b = {4'd4, 4'd8, 4'd3, 4'd6};
    cycle(4'b1010, a, b, 1'b1, acc);
    chk("fair_first", 32'(bus.req_ready), 32'b1000);
    cycle(4'b0000, a, b, 1'b1, acc);
    cycle(4'b0000, a, b, 1'b1, acc);
    cycle(4'b1010, a, b, 1'b1, acc);
    chk("fair_second", 32'(bus.req_ready), 32'b0010);
    cycle(4'b0000, a, b, 1'b1, acc);
    cycle(4'b0000, a, b, 1'b1, acc);

    // Backpressure: response held for 10 cycles with every requester valid.
    cycle(4'b1111, a, b, 1'b0, acc);
    cycle(4'b1111, a, b, 1'b0, acc);
    repeat (10) cycle(4'b1111, a, b, 1'b0, acc);
    cycle(4'b0000, a, b, 1'b1, acc);
    cycle(4'b0000, a, b, 1'b1, acc);
    chk("bp_count", 32'(op_count), 32'd4);

    // Reset in the middle of a multiply: the transaction is dropped.
    a = {4'd3, 4'd7, 4'd9, 4'd6};
    b = {4'd2, 4'd5, 4'd7, 4'd6};
    cycle(4'b0010, a, b, 1'b1, acc);
    do_reset();
    cycle(4'b0001, a, b, 1'b1, acc);
    cycle(4'b0000, a, b, 1'b1, acc);
    cycle(4'b0000, a, b, 1'b1, acc);
    chk("post_rst_prod", 32'(bus.rsp_prod), 32'd36);
    chk("post_rst_id", 32'(bus.rsp_id), 32'd0);

    // All four requesters continuously valid from reset.
    do_reset();
    a = {4'd11, 4'd0, 4'd7, 4'd3};
    b = {4'd13, 4'd12, 4'd9, 4'd5};
    ids   = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    prods = '{8'd15, 8'd63, 8'd0, 8'd143, 8'd15};
    nseen = 0;
    repeat (15) begin
      cycle(4'b1111, a, b, 1'b1, acc);
      if (bus.rsp_valid && nseen < 5) begin
        chk("rr_id", 32'(bus.rsp_id), 32'(ids[nseen]));
        chk("rr_prod", 32'(bus.rsp_prod), 32'(prods[nseen]));
        nseen++;
      end
    end
    chk("rr_count", 32'(nseen), 32'd5);

    // Exhaustive operand sweep through requester 1.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a = '0; b = '0;
        a[7:4] = 4'(i); b[7:4] = 4'(j);
        cycle(4'b0010, a, b, 1'b1, acc);
        cycle(4'b0000, a, b, 1'b1, acc);
        cycle(4'b0000, a, b, 1'b1, acc);
      end
    end
    cycle(4'b0000, a, b, 1'b1, acc);
    chk("sweep_count", 32'(op_count), 32'd256);

    // Random traffic with random backpressure and requesters that may give up.
    v = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i]) begin
          if ($urandom % 3 == 0) begin
            v[i] = 1'b1;
            a[4*i +: 4] = 4'($urandom);
            b[4*i +: 4] = 4'($urandom);
          end
        end else if ($urandom % 10 == 0) begin
          v[i] = 1'b0;
        end
      end
      cycle(v, a, b, ($urandom % 4) != 0, acc);
      if (acc >= 0) v[acc] = 1'b0;
    end
    repeat (4) cycle(4'b0000, a, b, 1'b1, acc);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wallace_mul_arbiter.md
# wallace_mul_arbiter

Shares one 4x4 unsigned Wallace-tree multiplier among `NREQ` independent requesters. Each requester presents operands on a valid/ready channel; the arbiter grants one per transaction in round-robin order, registers the operands, drives the shared multiplier, and returns the 8-bit product on a single tagged response channel. It sits between client logic and the combinational `wallace` datapath, which is instantiated outside this block and connected through the `mul_*` ports.

## Interface
- `NREQ`, 4, number of requesters; legal range 2..8.
- `ID_W`, 2, requester tag width; must equal ceil(log2(NREQ)).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  bit i: requester i holds a valid operand pair.
- `req_ready`  out  NREQ  bit i: requester i accepted this cycle; at most one bit set.
- `req_a`  in  4*NREQ  operand A of requester i at bits [4i+3:4i].
- `req_b`  in  4*NREQ  operand B of requester i at bits [4i+3:4i].
- `rsp_valid`  out  1  response holds a valid product.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  ID_W  index of the requester that owns the response.
- `rsp_prod`  out  8  unsigned product A*B.
- `mul_a`, `mul_b`  out  4  operands driven to the shared multiplier.
- `mul_prod`  in  8  combinational product returned by the multiplier.
- `busy`  out  1  high whenever the state is not IDLE.
- `op_count`  out  16  completed responses, wraps 0xFFFF -> 0.

## Operation
- FSM states: IDLE, MUL, RESP.
- IDLE: grant g = first i with `req_valid[i]`=1, searching upward from pointer `ptr` modulo NREQ. `req_ready[g]`=1 combinationally; all other bits 0. No valid requester: stay in IDLE, `req_ready`=0.
- On the handshake (`req_valid[g]` & `req_ready[g]`): register `req_a[g]`, `req_b[g]` into the operand registers and g into the tag register; set `ptr` to (g+1) mod NREQ; go to MUL.
- MUL: `mul_a`/`mul_b` are driven from the operand registers, which are stable for the entire state. At the end of the cycle, capture `mul_prod` into `rsp_prod`, copy the tag to `rsp_id`, and go to RESP.
- RESP: `rsp_valid`=1. `rsp_prod` and `rsp_id` hold while `rsp_ready`=0. When `rsp_ready`=1: increment `op_count`, clear `rsp_valid`, go to IDLE.
- `req_ready` is 0 in MUL and RESP. A requester may deassert `req_valid` before being granted; no state is kept for it.
- Arithmetic: unsigned, no truncation; 15*15 = 225 fits in 8 bits.
- `mul_a`/`mul_b` hold their last value outside MUL.
- Reset (asynchronous, any state including mid-transaction):
  - state goes to IDLE, `ptr`=0;
  - `rsp_valid`=0, `rsp_prod`=0, `rsp_id`=0, `mul_a`=0, `mul_b`=0, `busy`=0, `op_count`=0;
  - `req_ready`=0 while `rst_n` is low;
  - any in-flight transaction is dropped with no response.

## Timing
- Accept at edge T (handshake in cycle T-1). MUL is cycle T. `rsp_valid` rises after edge T+1.
- Latency from handshake cycle to first `rsp_valid` cycle: 2 cycles.
- Minimum issue interval: 3 cycles per transaction with `rsp_ready` held high.
- The multiplier path `mul_a/mul_b -> mul_prod -> rsp_prod` must close in one clock period.
- `req_ready` depends combinationally on `req_valid` and `ptr`. Requesters must not make `req_valid` depend on `req_ready`.
- `rsp_valid` is registered and never drops without a handshake (except on reset).

## Test plan
- Single request: requester 2 sends a=4'd15, b=4'd15 -> `rsp_valid` 2 cycles after handshake, `rsp_prod`=8'd225, `rsp_id`=2, `op_count`=1.
- All four requesters valid continuously from reset, with operands (3,5), (7,9), (0,12), (11,13) -> responses in order id 0,1,2,3 with products 15, 63, 0, 143, then id 0 again.
- Backpressure: hold `rsp_ready`=0 for 10 cycles during RESP -> `rsp_valid`, `rsp_prod`, `rsp_id` stable; `req_ready`=0 throughout; exactly one `op_count` increment after release.
- Fairness: `ptr`=3, requesters 1 and 3 valid -> grant 3 first, then 1. No requester waits more than NREQ grants.
- Reset mid-operation: assert `rst_n`=0 during MUL -> all outputs zero immediately, no response emitted. After release, requester 0 with (6,6) -> product 36, `rsp_id`=0.
- Exhaustive sweep: all 256 (a,b) pairs via requester 1 -> `rsp_prod` == a*b each time; `op_count`=256.
